// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit arbiter.
//   arb_state_e   : arbiter FSM states
//   NREQ_DEFAULT  : default number of requesters
//   OWNER_W       : owner index width for the default requester count
package rs232_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StSkip,
        StDrain
    } arb_state_e;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned OWNER_W      = $clog2(NREQ_DEFAULT);

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// Combinational round-robin search.
//   req   : request vector
//   start : index searched first; the search wraps from N-1 to 0
//   gnt   : one-hot grant of the first set request found
//   idx   : binary index of that request
//   any   : at least one request is set
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(start) + off) % N;
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = W'(cand);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// Arbitrates NREQ byte sources onto one serial transmitter, with optional
// multi-byte locking and a forced release when a lock holder goes quiet.
//   clock, reset  : clock and synchronous active-high reset
//   req_valid     : per-requester byte offered
//   req_data      : per-requester byte, requester i in bits [8i+7:8i]
//   req_lock      : offered byte is not the last of a message
//   req_ready     : one-hot accept strobe (combinational)
//   tx_data       : byte handed to the transmitter
//   tx_start      : one-cycle launch pulse for the transmitter
//   tx_busy       : transmitter is shifting
//   owner         : lock holder, or last granted requester
//   locked        : owner holds a lock
//   lock_timeout  : one-cycle pulse when a lock is forcibly released
module rs232_tx_arbiter
    import rs232_pkg::*;
#(
    parameter int unsigned NREQ         = NREQ_DEFAULT,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_lock,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    locked,
    output logic                    lock_timeout
);

    localparam int unsigned OwnerW = $clog2(NREQ);
    localparam int unsigned CntW   = 20;
    localparam logic [CntW-1:0] TmoLast = CntW'(LOCK_TIMEOUT - 1);

    arb_state_e        state;
    logic [CntW-1:0]   tmo_cnt;

    logic [OwnerW-1:0] rr_start;
    logic [NREQ-1:0]   pick_gnt;
    logic [OwnerW-1:0] pick_idx;
    logic              pick_any;

    logic [NREQ-1:0]   win_gnt;
    logic [OwnerW-1:0] win_idx;
    logic              win_valid;
    logic [7:0]        win_byte;
    logic              grant_ok;
    logic              transfer;

    // Search starts just past the last owner so every requester gets a turn.
    assign rr_start = (owner == OwnerW'(NREQ - 1)) ? '0 : owner + 1'b1;

    rr_pick #(
        .N (NREQ),
        .W (OwnerW)
    ) u_rr_pick (
        .req   (req_valid),
        .start (rr_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A held lock bypasses round-robin: only the owner may be granted.
    always_comb begin
        win_gnt   = '0;
        win_idx   = owner;
        win_valid = 1'b0;
        win_byte  = 8'h00;
        if (locked) begin
            win_valid      = req_valid[owner];
            win_gnt[owner] = req_valid[owner];
        end else begin
            win_valid = pick_any;
            win_idx   = pick_idx;
            win_gnt   = pick_gnt;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == OwnerW'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    assign grant_ok  = (state == StIdle) && !tx_busy && !reset;
    assign req_ready = grant_ok ? win_gnt : '0;
    assign transfer  = grant_ok && win_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StIdle;
            owner        <= OwnerW'(NREQ - 1);
            locked       <= 1'b0;
            lock_timeout <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            tmo_cnt      <= '0;
        end else begin
            tx_start     <= 1'b0;
            lock_timeout <= 1'b0;
            if (!locked) begin
                tmo_cnt <= '0;
            end
            case (state)
                StIdle: begin
                    // A transfer from the owner always beats the timeout.
                    if (transfer) begin
                        tx_data  <= win_byte;
                        owner    <= win_idx;
                        locked   <= req_lock[win_idx];
                        tmo_cnt  <= '0;
                        tx_start <= 1'b1;
                        state    <= StStart;
                    end else if (locked && !req_valid[owner]) begin
                        if (tmo_cnt == TmoLast) begin
                            locked       <= 1'b0;
                            lock_timeout <= 1'b1;
                            tmo_cnt      <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                StStart: state <= StSkip;
                // tx_busy only rises the cycle after tx_start, so it is not
                // trusted until one cycle later.
                StSkip:  state <= StDrain;
                StDrain: begin
                    if (!tx_busy) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/rs232_tx_arbiter.md
RS232_TX_ARBITER -- requirements
Module: rs232_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: IDLE cycles without owner valid before a held lock is forcibly released, range 1..2^20-1.
REQ-003 clock  in  1  sole clock, all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NREQ  requester i has a byte offered.
REQ-006 req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i].
REQ-007 req_lock  in  NREQ  offered byte is not the last of a message; keep the grant.
REQ-008 req_ready  out  NREQ  one-hot accept strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high at a posedge.
REQ-009 tx_data  out  8  byte presented to the serial transmitter.
REQ-010 tx_start  out  1  one-cycle pulse; the transmitter latches tx_data.
REQ-011 tx_busy  in  1  transmitter shifting; rises the cycle after tx_start, falls after the stop bit.
REQ-012 owner  out  clog2(NREQ)  index of the lock holder, or the last granted requester.
REQ-013 locked  out  1  a lock is held by owner.
REQ-014 lock_timeout  out  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-015 FSM states: IDLE, START, SKIP, DRAIN. No other states are reachable.
REQ-016 In IDLE with tx_busy=0, the winner is chosen combinationally:
- if locked: owner when req_valid[owner]=1, else none;
- else: first valid requester in round-robin order starting at owner+1 mod NREQ.
REQ-017 req_ready is high only in IDLE with tx_busy=0, for the winner only, and never depends on the winner's own req_data.
REQ-018 On transfer:
- capture req_data into tx_data;
- set owner to the winner;
- set locked to req_lock[winner];
- go to START.
REQ-019 START: tx_start=1 for exactly this cycle; next state SKIP.
REQ-020 SKIP: ignore tx_busy for one cycle; next state DRAIN.
REQ-021 DRAIN: hold until tx_busy=0, then go to IDLE; tx_data holds its value.
REQ-022 Latency: transfer at edge k gives tx_start high in cycle k+1. Minimum spacing between consecutive tx_start pulses is 4 cycles.
REQ-023 While locked, other requesters see req_ready=0 regardless of req_valid; non-owner requests never starve an owner that keeps req_valid high.
REQ-024 Lock timeout counter:
- counts cycles in IDLE while locked and req_valid[owner]=0;
- clears on any transfer or when not locked;
- on reaching LOCK_TIMEOUT: locked<=0 and lock_timeout=1 for one cycle;
- arbitration resumes round-robin in the following cycle.
REQ-025 A timeout and a transfer from owner in the same cycle: the transfer wins and no timeout pulse is generated.
REQ-026 tx_busy=1 while in IDLE (external or late busy): no grant until tx_busy=0.
REQ-027 req_valid deasserted before acceptance loses nothing; the arbiter holds no per-requester storage.
REQ-028 Round-robin wrap: owner=NREQ-1 searches from requester 0.

Reset
REQ-029 reset in any state, including mid-DRAIN, forces:
- state IDLE;
- owner=NREQ-1, so requester 0 has first priority;
- locked=0, lock_timeout=0, tx_start=0, req_ready=0, tx_data=0;
- timeout counter=0.
REQ-030 The cycle after reset deassertion may grant if tx_busy=0. A transmission in progress is not tracked after reset.
REQ-031 Reset overrides all other inputs in the same cycle.

Structure
REQ-032 Shared package rs232_pkg holds:
- the state enumeration;
- the NREQ default;
- the OWNER_W = clog2(NREQ) helper constant.
REQ-033 The round-robin winner search is a combinational sub-module rr_pick:
- inputs: request vector, start index;
- outputs: one-hot grant, index, any.
REQ-034 All outputs except req_ready are registered.

Verification
REQ-035 Scenario 1, single byte: requester 2 offers 0x5A, req_lock=0, tx_busy idle.
- req_ready[2] in cycle 0; tx_start with tx_data=0x5A in cycle 1.
- Bench asserts tx_busy for 10 cycles; next grant no earlier than after tx_busy falls.
REQ-036 Scenario 2, fairness: all 4 valid continuously, no locks.
- Grant order after reset is 0,1,2,3,0.
REQ-037 Scenario 3, lock: requester 1 sends 0x10 (lock=1), 0x11 (lock=1), 0x12 (lock=0) while 0 and 3 are valid.
- Bytes 0x10,0x11,0x12 go out consecutively;
- locked falls after 0x12;
- next grant goes to 3.
REQ-038 Scenario 4, timeout: LOCK_TIMEOUT=8; requester 0 sends with lock=1, then drops valid.
- lock_timeout pulses exactly 8 IDLE cycles after DRAIN exit;
- requester 1 is granted the following cycle.
REQ-039 Scenario 5, reset: reset asserted in DRAIN with tx_busy=1.
- Next cycle: all outputs at reset values;
- no grant until tx_busy=0;
- requester 0 has first priority.
